// File: rtl/uart_stream.sv
// uart_stream: UART transceiver with valid/ready streams, RX/TX FIFOs and
// RTS/CTS hardware flow control. One shared baud tick drives both directions.

// Synchronous FIFO with an occupancy count; pointers wrap on the power-of-two depth.
module uart_stream_fifo #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     wr_i,
    input  logic [Width-1:0]         wdata_i,
    input  logic                     rd_i,
    output logic [Width-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(Depth):0]   count_o
);
    localparam int unsigned AW = $clog2(Depth);

    logic [Width-1:0] mem [Depth];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [AW:0]      count;
    logic             do_wr;
    logic             do_rd;

    assign empty_o = (count == '0);
    assign full_o  = (count == (AW+1)'(Depth));
    assign count_o = count;
    assign rdata_o = mem[rptr];

    // A pop on empty is ignored; a push on full is accepted only alongside a real pop.
    assign do_rd = rd_i && !empty_o;
    assign do_wr = wr_i && (!full_o || do_rd);

    // Storage array, no reset needed since the pointers define validity.
    always_ff @(posedge clk_i) begin
        if (do_wr) begin
            mem[wptr] <= wdata_i;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_wr) wptr <= wptr + AW'(1);
            if (do_rd) rptr <= rptr + AW'(1);
            case ({do_wr, do_rd})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

module uart_stream #(
    parameter int unsigned DataWidth    = 8,
    parameter int unsigned FifoDepth    = 16,
    parameter int unsigned Oversample   = 16,
    parameter int unsigned RtsThreshold = FifoDepth - 2
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [15:0]          divisor_i,
    input  logic                 parity_en_i,
    input  logic                 parity_odd_i,
    input  logic                 two_stop_i,
    input  logic [DataWidth-1:0] tx_data_i,
    input  logic                 tx_valid_i,
    output logic                 tx_ready_o,
    output logic [DataWidth-1:0] rx_data_o,
    output logic                 rx_valid_o,
    input  logic                 rx_ready_i,
    output logic [3:0]           rx_err_o,
    input  logic                 rxd_i,
    output logic                 txd_o,
    input  logic                 cts_ni,
    output logic                 rts_no,
    output logic                 tx_busy_o
);
    localparam int unsigned OW = $clog2(Oversample);
    localparam int unsigned BW = $clog2(DataWidth);
    localparam int unsigned CW = $clog2(FifoDepth) + 1;
    localparam int unsigned RW = DataWidth + 4;

    localparam logic [OW-1:0] OS_LAST  = OW'(Oversample - 1);
    localparam logic [OW-1:0] OS_HALF  = OW'(Oversample / 2 - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DataWidth - 1);
    localparam logic [CW-1:0] RTS_LVL  = CW'(RtsThreshold);

    typedef enum logic [2:0] {
        TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP1, TX_STOP2
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP
    } rx_state_t;

    // ---------------- baud tick ----------------
    logic [15:0] div_eff;
    logic [15:0] baud_cnt;
    logic        tick;

    assign div_eff = (divisor_i == '0) ? 16'd1 : divisor_i;
    // ">=" keeps the counter from running away if the divisor shrinks mid-count.
    assign tick    = (baud_cnt >= div_eff - 16'd1);

    // Free-running oversample tick generator.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) baud_cnt <= '0;
        else         baud_cnt <= tick ? '0 : baud_cnt + 16'd1;
    end

    // ---------------- synchronizers ----------------
    logic [1:0] rxd_sync;
    logic [1:0] cts_sync;
    logic       rxd_prev;
    logic       rxd_s;
    logic       cts_s;

    assign rxd_s = rxd_sync[1];
    assign cts_s = cts_sync[1];

    // Two-flop synchronizers; both lines reset to their idle/not-clear level.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rxd_sync <= 2'b11;
            cts_sync <= 2'b11;
            rxd_prev <= 1'b1;
        end else begin
            rxd_sync <= {rxd_sync[0], rxd_i};
            cts_sync <= {cts_sync[0], cts_ni};
            rxd_prev <= rxd_sync[1];
        end
    end

    // ---------------- FIFOs ----------------
    logic [DataWidth-1:0] tx_fifo_data;
    logic                 tx_full;
    logic                 tx_empty;
    logic [CW-1:0]        tx_count;
    logic                 tx_pop;

    logic [RW-1:0]        rx_fifo_data;
    logic                 rx_full;
    logic                 rx_empty;
    logic [CW-1:0]        rx_count;
    logic                 rx_push;
    logic [RW-1:0]        rx_word;

    uart_stream_fifo #(.Width(DataWidth), .Depth(FifoDepth)) tx_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .wr_i    (tx_valid_i),
        .wdata_i (tx_data_i),
        .rd_i    (tx_pop),
        .rdata_o (tx_fifo_data),
        .full_o  (tx_full),
        .empty_o (tx_empty),
        .count_o (tx_count)
    );

    uart_stream_fifo #(.Width(RW), .Depth(FifoDepth)) rx_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .wr_i    (rx_push),
        .wdata_i (rx_word),
        .rd_i    (rx_ready_i),
        .rdata_o (rx_fifo_data),
        .full_o  (rx_full),
        .empty_o (rx_empty),
        .count_o (rx_count)
    );

    assign tx_ready_o = !tx_full;
    assign rx_valid_o = !rx_empty;
    assign rx_data_o  = rx_empty ? '0 : rx_fifo_data[DataWidth-1:0];
    assign rx_err_o   = rx_empty ? '0 : rx_fifo_data[RW-1:DataWidth];

    // ---------------- transmitter ----------------
    tx_state_t            tx_state, tx_state_d;
    logic [OW-1:0]        tx_cnt, tx_cnt_d;
    logic [BW-1:0]        tx_bit, tx_bit_d;
    logic [DataWidth-1:0] tx_shift, tx_shift_d;
    logic                 tx_par, tx_par_d;
    logic                 tx_par_en, tx_par_en_d;
    logic                 tx_two_stop, tx_two_stop_d;
    logic                 tx_bit_end;

    assign tx_busy_o = (tx_count != '0) || (tx_state != TX_IDLE);

    // TX state and frame registers; reset drops straight to IDLE so txd_o idles high.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tx_state    <= TX_IDLE;
            tx_cnt      <= '0;
            tx_bit      <= '0;
            tx_shift    <= '0;
            tx_par      <= 1'b0;
            tx_par_en   <= 1'b0;
            tx_two_stop <= 1'b0;
        end else begin
            tx_state    <= tx_state_d;
            tx_cnt      <= tx_cnt_d;
            tx_bit      <= tx_bit_d;
            tx_shift    <= tx_shift_d;
            tx_par      <= tx_par_d;
            tx_par_en   <= tx_par_en_d;
            tx_two_stop <= tx_two_stop_d;
        end
    end

    // TX next-state, FIFO pop and serial output.
    always_comb begin
        tx_state_d    = tx_state;
        tx_cnt_d      = tx_cnt;
        tx_bit_d      = tx_bit;
        tx_shift_d    = tx_shift;
        tx_par_d      = tx_par;
        tx_par_en_d   = tx_par_en;
        tx_two_stop_d = tx_two_stop;
        tx_pop        = 1'b0;
        txd_o         = 1'b1;
        tx_bit_end    = tick && (tx_cnt == OS_LAST);

        if (tx_state != TX_IDLE && tick) begin
            tx_cnt_d = tx_bit_end ? '0 : tx_cnt + OW'(1);
        end

        case (tx_state)
            TX_IDLE: begin
                if (tick && !tx_empty && !cts_s) begin
                    tx_pop        = 1'b1;
                    tx_state_d    = TX_START;
                    tx_cnt_d      = '0;
                    tx_bit_d      = '0;
                    tx_shift_d    = tx_fifo_data;
                    tx_par_d      = (^tx_fifo_data) ^ parity_odd_i;
                    tx_par_en_d   = parity_en_i;
                    tx_two_stop_d = two_stop_i;
                end
            end
            TX_START: begin
                txd_o = 1'b0;
                if (tx_bit_end) tx_state_d = TX_DATA;
            end
            TX_DATA: begin
                txd_o = tx_shift[0];
                if (tx_bit_end) begin
                    tx_shift_d = {1'b0, tx_shift[DataWidth-1:1]};
                    if (tx_bit == BIT_LAST) tx_state_d = tx_par_en ? TX_PARITY : TX_STOP1;
                    else                    tx_bit_d   = tx_bit + BW'(1);
                end
            end
            TX_PARITY: begin
                txd_o = tx_par;
                if (tx_bit_end) tx_state_d = TX_STOP1;
            end
            TX_STOP1: begin
                if (tx_bit_end) tx_state_d = tx_two_stop ? TX_STOP2 : TX_IDLE;
            end
            TX_STOP2: begin
                if (tx_bit_end) tx_state_d = TX_IDLE;
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    // ---------------- receiver ----------------
    rx_state_t            rx_state, rx_state_d;
    logic [OW-1:0]        rx_cnt, rx_cnt_d;
    logic [BW-1:0]        rx_bit, rx_bit_d;
    logic [DataWidth-1:0] rx_shift, rx_shift_d;
    logic                 rx_par_bit, rx_par_bit_d;
    logic                 rx_par_en, rx_par_en_d;
    logic                 rx_par_odd, rx_par_odd_d;
    logic                 overrun, overrun_d;
    logic                 rx_sample;
    logic                 rx_room;
    logic                 err_par;
    logic                 err_frame;
    logic                 err_break;

    // RX state, frame registers and sticky overrun.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rx_state   <= RX_IDLE;
            rx_cnt     <= '0;
            rx_bit     <= '0;
            rx_shift   <= '0;
            rx_par_bit <= 1'b0;
            rx_par_en  <= 1'b0;
            rx_par_odd <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            rx_state   <= rx_state_d;
            rx_cnt     <= rx_cnt_d;
            rx_bit     <= rx_bit_d;
            rx_shift   <= rx_shift_d;
            rx_par_bit <= rx_par_bit_d;
            rx_par_en  <= rx_par_en_d;
            rx_par_odd <= rx_par_odd_d;
            overrun    <= overrun_d;
        end
    end

    // RX next-state, mid-bit sampling, error classification and FIFO push.
    always_comb begin
        rx_state_d   = rx_state;
        rx_cnt_d     = rx_cnt;
        rx_bit_d     = rx_bit;
        rx_shift_d   = rx_shift;
        rx_par_bit_d = rx_par_bit;
        rx_par_en_d  = rx_par_en;
        rx_par_odd_d = rx_par_odd;
        overrun_d    = overrun;
        rx_push      = 1'b0;
        rx_sample    = tick && (rx_cnt == OS_LAST);
        rx_room      = !rx_full || rx_ready_i;
        err_par      = rx_par_en && (rx_par_bit != ((^rx_shift) ^ rx_par_odd));
        err_frame    = !rxd_s;
        err_break    = (rx_shift == '0) && !rxd_s && (!rx_par_en || !rx_par_bit);
        rx_word      = {err_break, overrun, err_frame, err_par, rx_shift};

        // START uses a half-bit period so every later sample lands mid-bit.
        if (rx_state != RX_IDLE && tick) begin
            if (rx_sample || (rx_state == RX_START && rx_cnt == OS_HALF)) rx_cnt_d = '0;
            else                                                          rx_cnt_d = rx_cnt + OW'(1);
        end

        case (rx_state)
            RX_IDLE: begin
                if (rxd_prev && !rxd_s) begin
                    rx_state_d   = RX_START;
                    rx_cnt_d     = '0;
                    rx_bit_d     = '0;
                    rx_par_en_d  = parity_en_i;
                    rx_par_odd_d = parity_odd_i;
                end
            end
            RX_START: begin
                if (tick && rx_cnt == OS_HALF) rx_state_d = rxd_s ? RX_IDLE : RX_DATA;
            end
            RX_DATA: begin
                if (rx_sample) begin
                    rx_shift_d = {rxd_s, rx_shift[DataWidth-1:1]};
                    if (rx_bit == BIT_LAST) rx_state_d = rx_par_en ? RX_PARITY : RX_STOP;
                    else                    rx_bit_d   = rx_bit + BW'(1);
                end
            end
            RX_PARITY: begin
                if (rx_sample) begin
                    rx_par_bit_d = rxd_s;
                    rx_state_d   = RX_STOP;
                end
            end
            RX_STOP: begin
                if (rx_sample) begin
                    rx_state_d = RX_IDLE;
                    if (rx_room) begin
                        rx_push   = 1'b1;
                        overrun_d = 1'b0;
                    end else begin
                        overrun_d = 1'b1;
                    end
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // Registered RTS from RX occupancy.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) rts_no <= 1'b0;
        else         rts_no <= (rx_count >= RTS_LVL);
    end
endmodule
